// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALUControl operation codes, main-decoder ALUOp classes
// and the operand forwarding-select codes used by the issue stage.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R_I = 2'b10;
  localparam logic [1:0] ALUOP_U   = 2'b11;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps main-decoder ALUOp plus {op[5], funct7[5], funct3} onto
// the 3-bit ALUControl code. Purely combinational; shared with the single-cycle core.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [4:0] funct_i,
  output logic [2:0] alu_control_o
);

  logic       op5;
  logic       f7b5;
  logic [2:0] funct3;

  assign op5    = funct_i[4];
  assign f7b5   = funct_i[3];
  assign funct3 = funct_i[2:0];

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_MEM: alu_control_o = ALU_ADD;
      ALUOP_BR:  alu_control_o = ALU_SUB;
      ALUOP_U:   alu_control_o = ALU_ADD;
      ALUOP_R_I: begin
        case (funct3)
          // Only R-type (op[5]=1) with funct7[5] subtracts; addi never does.
          3'b000:  alu_control_o = (op5 & f7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control_o = ALU_SLL;
          3'b010:  alu_control_o = ALU_SLT;
          3'b011:  alu_control_o = ALU_ADD;
          3'b100:  alu_control_o = ALU_XOR;
          3'b101:  alu_control_o = ALU_SRL;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline boundary: registers decoded control and operands, then drives
// ALUControl/SrcA/SrcB in EX with EX/MEM and MEM/WB forwarding applied.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ID_Valid,
  input  logic [1:0]      ID_ALUOp,
  input  logic [4:0]      ID_Funct,
  input  logic            ID_ALUSrc,
  input  logic            ID_RegWrite,
  input  logic [XLEN-1:0] ID_RD1,
  input  logic [XLEN-1:0] ID_RD2,
  input  logic [XLEN-1:0] ID_ImmExt,
  input  logic [RW-1:0]   ID_Rs1,
  input  logic [RW-1:0]   ID_Rs2,
  input  logic [RW-1:0]   ID_Rd,
  input  logic            Stall,
  input  logic            Flush,
  input  logic            MEM_RegWrite,
  input  logic [RW-1:0]   MEM_Rd,
  input  logic [XLEN-1:0] MEM_ALUResult,
  input  logic            WB_RegWrite,
  input  logic [RW-1:0]   WB_Rd,
  input  logic [XLEN-1:0] WB_Result,
  output logic            EX_Valid,
  output logic            EX_RegWrite,
  output logic [RW-1:0]   EX_Rd,
  output logic [2:0]      ALUControl,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  output logic [XLEN-1:0] EX_WriteData
);

  logic [2:0] id_alu_ctl;

  logic            valid_q,    valid_d;
  logic            regwrite_q, regwrite_d;
  logic            alusrc_q,   alusrc_d;
  logic [2:0]      alu_ctl_q,  alu_ctl_d;
  logic [XLEN-1:0] rd1_q,      rd1_d;
  logic [XLEN-1:0] rd2_q,      rd2_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic [RW-1:0]   rs1_q,      rs1_d;
  logic [RW-1:0]   rs2_q,      rs2_d;
  logic [RW-1:0]   rd_q,       rd_d;

  logic [1:0]      fwd_a_sel, fwd_b_sel;
  logic [XLEN-1:0] fwd_a, fwd_b;

  function automatic logic [1:0] fwd_select(
    input logic [RW-1:0] rs,
    input logic          mem_we,
    input logic [RW-1:0] mem_rd,
    input logic          wb_we,
    input logic [RW-1:0] wb_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != '0) begin
      if (mem_we && (mem_rd == rs))    sel = FWD_MEM;
      else if (wb_we && (wb_rd == rs)) sel = FWD_WB;
    end
    return sel;
  endfunction

  alu_decoder u_alu_decoder (
    .alu_op_i      (ID_ALUOp),
    .funct_i       (ID_Funct),
    .alu_control_o (id_alu_ctl)
  );

  // ID side: next-state selection, Flush > Stall > load
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    alusrc_d   = alusrc_q;
    alu_ctl_d  = alu_ctl_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    if (Flush || (!Stall && !ID_Valid)) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      alusrc_d   = 1'b0;
      alu_ctl_d  = ALU_ADD;
      rd1_d      = '0;
      rd2_d      = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
    end else if (!Stall) begin
      valid_d    = 1'b1;
      regwrite_d = ID_RegWrite;
      alusrc_d   = ID_ALUSrc;
      alu_ctl_d  = id_alu_ctl;
      rd1_d      = ID_RD1;
      rd2_d      = ID_RD2;
      imm_d      = ID_ImmExt;
      rs1_d      = ID_Rs1;
      rs2_d      = ID_Rs2;
      rd_d       = ID_Rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      alu_ctl_q  <= ALU_ADD;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      alusrc_q   <= alusrc_d;
      alu_ctl_q  <= alu_ctl_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
    end
  end

  // EX side: forwarding tracks the live MEM/WB ports, including while stalled
  assign fwd_a_sel = fwd_select(rs1_q, MEM_RegWrite, MEM_Rd, WB_RegWrite, WB_Rd);
  assign fwd_b_sel = fwd_select(rs2_q, MEM_RegWrite, MEM_Rd, WB_RegWrite, WB_Rd);

  always_comb begin
    fwd_a = rd1_q;
    case (fwd_a_sel)
      FWD_MEM: fwd_a = MEM_ALUResult;
      FWD_WB:  fwd_a = WB_Result;
      default: fwd_a = rd1_q;
    endcase
  end

  always_comb begin
    fwd_b = rd2_q;
    case (fwd_b_sel)
      FWD_MEM: fwd_b = MEM_ALUResult;
      FWD_WB:  fwd_b = WB_Result;
      default: fwd_b = rd2_q;
    endcase
  end

  assign EX_Valid     = valid_q;
  assign EX_RegWrite  = regwrite_q & valid_q;
  assign EX_Rd        = rd_q;
  assign ALUControl   = alu_ctl_q;
  assign SrcA         = fwd_a;
  assign SrcB         = alusrc_q ? imm_q : fwd_b;
  assign EX_WriteData = fwd_b;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed plus randomized bench for alu_issue_stage, checked against a
// behavioural model of the ID/EX register and forwarding rules.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ID_Valid;
  logic [1:0]  ID_ALUOp;
  logic [4:0]  ID_Funct;
  logic        ID_ALUSrc;
  logic        ID_RegWrite;
  logic [31:0] ID_RD1, ID_RD2, ID_ImmExt;
  logic [4:0]  ID_Rs1, ID_Rs2, ID_Rd;
  logic        Stall, Flush;
  logic        MEM_RegWrite;
  logic [4:0]  MEM_Rd;
  logic [31:0] MEM_ALUResult;
  logic        WB_RegWrite;
  logic [4:0]  WB_Rd;
  logic [31:0] WB_Result;
  logic        EX_Valid, EX_RegWrite;
  logic [4:0]  EX_Rd;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA, SrcB, EX_WriteData;

  int n_cmp = 0;
  int n_err = 0;

  // Model of the EX instruction slot
  logic        m_valid, m_rw, m_alusrc;
  logic [2:0]  m_ctl;
  logic [31:0] m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Valid(ID_Valid), .ID_ALUOp(ID_ALUOp), .ID_Funct(ID_Funct),
    .ID_ALUSrc(ID_ALUSrc), .ID_RegWrite(ID_RegWrite),
    .ID_RD1(ID_RD1), .ID_RD2(ID_RD2), .ID_ImmExt(ID_ImmExt),
    .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_Rd(ID_Rd),
    .Stall(Stall), .Flush(Flush),
    .MEM_RegWrite(MEM_RegWrite), .MEM_Rd(MEM_Rd), .MEM_ALUResult(MEM_ALUResult),
    .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .WB_Result(WB_Result),
    .EX_Valid(EX_Valid), .EX_RegWrite(EX_RegWrite), .EX_Rd(EX_Rd),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .EX_WriteData(EX_WriteData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected operation, written as the instruction-level meaning of the fields
  function automatic logic [2:0] ref_decode(input logic [1:0] aluop, input logic [4:0] f);
    if (aluop == 2'b01) return 3'b001;
    if (aluop != 2'b10) return 3'b000;
    case (f[2:0])
      3'd0: return (f[4] && f[3]) ? 3'b001 : 3'b000;
      3'd1: return 3'b111;
      3'd2: return 3'b101;
      3'd4: return 3'b110;
      3'd5: return 3'b100;
      3'd6: return 3'b011;
      3'd7: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] regval);
    if (rs == 5'd0) return regval;
    if (MEM_RegWrite && MEM_Rd == rs) return MEM_ALUResult;
    if (WB_RegWrite && WB_Rd == rs) return WB_Result;
    return regval;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_alusrc = 0; m_ctl = 0;
    m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {31'd0, EX_Valid}, {31'd0, m_valid});
    chk({tag, ".regwrite"}, {31'd0, EX_RegWrite}, {31'd0, m_rw & m_valid});
    chk({tag, ".rd"}, {27'd0, EX_Rd}, {27'd0, m_rd});
    chk({tag, ".ctl"}, {29'd0, ALUControl}, {29'd0, m_ctl});
    chk({tag, ".srca"}, SrcA, ref_operand(m_rs1, m_rd1));
    chk({tag, ".srcb"}, SrcB, m_alusrc ? m_imm : ref_operand(m_rs2, m_rd2));
    chk({tag, ".wdata"}, EX_WriteData, ref_operand(m_rs2, m_rd2));
  endtask

  // One clock edge; model follows Flush > Stall > load
  task automatic step();
    logic flush_s, stall_s, valid_s;
    flush_s = Flush; stall_s = Stall; valid_s = ID_Valid;
    @(posedge clk);
    #1;
    if (flush_s || (!stall_s && !valid_s)) model_clear();
    else if (!stall_s) begin
      m_valid = 1; m_rw = ID_RegWrite; m_alusrc = ID_ALUSrc;
      m_ctl = ref_decode(ID_ALUOp, ID_Funct);
      m_rd1 = ID_RD1; m_rd2 = ID_RD2; m_imm = ID_ImmExt;
      m_rs1 = ID_Rs1; m_rs2 = ID_Rs2; m_rd = ID_Rd;
    end
  endtask

  task automatic id_idle();
    ID_Valid = 0; ID_ALUOp = 0; ID_Funct = 0; ID_ALUSrc = 0; ID_RegWrite = 0;
    ID_RD1 = 0; ID_RD2 = 0; ID_ImmExt = 0; ID_Rs1 = 0; ID_Rs2 = 0; ID_Rd = 0;
  endtask

  task automatic fwd_idle();
    MEM_RegWrite = 0; MEM_Rd = 0; MEM_ALUResult = 0;
    WB_RegWrite = 0; WB_Rd = 0; WB_Result = 0;
  endtask

  initial begin
    rst_n = 0; Stall = 0; Flush = 0;
    id_idle(); fwd_idle(); model_clear();
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1;

    // Decode sweep for R/I class and the other ALUOp classes
    for (int f = 0; f < 32; f++) begin
      id_idle(); ID_Valid = 1; ID_ALUOp = 2'b10; ID_Funct = f[4:0];
      ID_Rd = f[4:0]; ID_RegWrite = 1;
      step();
      check_all("decode");
    end
    ID_Funct = 5'b11000; ID_ALUOp = 2'b10; step();
    chk("decode.sub_const", {29'd0, ALUControl}, 32'd1);
    ID_Funct = 5'b00101; step();
    chk("decode.srl_const", {29'd0, ALUControl}, 32'd4);
    ID_Funct = 5'b00010; step();
    chk("decode.slt_const", {29'd0, ALUControl}, 32'd5);
    for (int op = 0; op < 4; op++) begin
      ID_ALUOp = op[1:0]; ID_Funct = 5'b11000;
      step();
      check_all("decode.aluop");
    end

    // Forward priority MEM over WB
    id_idle(); ID_Valid = 1; ID_Rs1 = 5; ID_RD1 = 32'hAA;
    step();
    MEM_RegWrite = 1; MEM_Rd = 5; MEM_ALUResult = 32'h11;
    WB_RegWrite = 1; WB_Rd = 5; WB_Result = 32'h22;
    #1;
    chk("fwd.mem_prio", SrcA, 32'h11);
    check_all("fwd.mem_prio");
    MEM_RegWrite = 0;
    #1;
    chk("fwd.wb", SrcA, 32'h22);
    check_all("fwd.wb");
    fwd_idle();

    // x0 is never forwarded
    id_idle(); ID_Valid = 1; ID_Rs2 = 0; ID_RD2 = 0;
    MEM_RegWrite = 1; MEM_Rd = 0; MEM_ALUResult = 32'hDEAD;
    step();
    chk("x0.srcb", SrcB, 32'h0);
    chk("x0.wdata", EX_WriteData, 32'h0);
    fwd_idle();

    // Stall holds, Stall+Flush bubbles
    id_idle(); ID_Valid = 1; ID_ALUOp = 2'b00; ID_Rd = 7; ID_RegWrite = 1;
    step();
    Stall = 1; ID_Rd = 9; ID_ALUOp = 2'b01;
    step(); step();
    chk("stall.rd", {27'd0, EX_Rd}, 32'd7);
    chk("stall.valid", {31'd0, EX_Valid}, 32'd1);
    check_all("stall");
    Flush = 1;
    step();
    chk("flush.valid", {31'd0, EX_Valid}, 32'd0);
    chk("flush.regwrite", {31'd0, EX_RegWrite}, 32'd0);
    check_all("flush");
    Stall = 0; Flush = 0;

    // Immediate operand vs forwarded store data
    id_idle(); ID_Valid = 1; ID_ALUSrc = 1; ID_ImmExt = 32'hFFFF_FFFC; ID_Rs2 = 3;
    step();
    MEM_RegWrite = 1; MEM_Rd = 3; MEM_ALUResult = 32'h33;
    #1;
    chk("alusrc.srcb", SrcB, 32'hFFFF_FFFC);
    chk("alusrc.wdata", EX_WriteData, 32'h33);
    fwd_idle();

    // Randomized traffic; MEM/WB ports also change while EX is held
    for (int i = 0; i < 400; i++) begin
      ID_Valid = ($urandom_range(0, 7) != 0);
      ID_ALUOp = 2'($urandom_range(0, 3));
      ID_Funct = 5'($urandom_range(0, 31));
      ID_ALUSrc = 1'($urandom_range(0, 1));
      ID_RegWrite = 1'($urandom_range(0, 1));
      ID_RD1 = $urandom; ID_RD2 = $urandom; ID_ImmExt = $urandom;
      ID_Rs1 = 5'($urandom_range(0, 3)); ID_Rs2 = 5'($urandom_range(0, 3));
      ID_Rd = 5'($urandom_range(0, 31));
      Stall = ($urandom_range(0, 4) == 0);
      Flush = ($urandom_range(0, 7) == 0);
      step();
      MEM_RegWrite = 1'($urandom_range(0, 1)); MEM_Rd = 5'($urandom_range(0, 3));
      MEM_ALUResult = $urandom;
      WB_RegWrite = 1'($urandom_range(0, 1)); WB_Rd = 5'($urandom_range(0, 3));
      WB_Result = $urandom;
      #1;
      check_all("rand");
    end
    Stall = 0; Flush = 0; fwd_idle();

    // Asynchronous reset between edges
    id_idle(); ID_Valid = 1; ID_ALUOp = 2'b10; ID_Funct = 5'b00111; ID_RegWrite = 1; ID_Rd = 4;
    step();
    chk("areset.pre_valid", {31'd0, EX_Valid}, 32'd1);
    #2;
    rst_n = 0;
    #1;
    model_clear();
    chk("areset.valid", {31'd0, EX_Valid}, 32'd0);
    chk("areset.ctl", {29'd0, ALUControl}, 32'd0);
    check_all("areset");
    rst_n = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
